// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The optional signed-overflow output is enabled by SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow-out bout.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e             state, state_next;
  logic [WIDTH-1:0]   a_sh, b_sh, d_sh, d_sh_next;
  logic [CNT_W-1:0]   cnt;
  logic               bor;
  logic               d_bit, bout;
  logic               load, step, finish;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (bor),
    .d    (d_bit),
    .bout (bout)
  );

  // Result bits enter at the MSB so the LSB-first stream ends up in place.
  assign d_sh_next = {d_bit, d_sh[WIDTH-1:1]};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: operand shifters, result shifter, borrow FF, bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      bor  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      d_sh <= '0;
      bor  <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= d_sh_next;
      bor  <= bout;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Results are updated only on the completion edge and held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        diff   <= d_sh_next;
        borrow <= bout;
        zero   <= (d_sh_next == '0);
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // Sign bits are captured at start since the operand shifters consume them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (finish) ovf <= (a_msb ^ b_msb) & (a_msb ^ d_sh_next[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver queues expected results, monitor checks on done.
module tb_serial_subtractor;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, zero;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic z, input logic o);
    exp_t e;
    e.diff = d; e.borrow = bo; e.zero = z; e.ovf = o;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("borrow", 32'(borrow), 32'(e.borrow));
        chk("zero", 32'(zero), 32'(e.zero));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Issue one operation and check latency; operands are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
    int k;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
    chk("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (done !== 1'b1 && k < 100);
    chk("latency", 32'(k), 32'(W));
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;

    run_op(16'h0005, 16'h0003, mk(16'h0002, 1'b0, 1'b0, 1'b0));
    run_op(16'h0003, 16'h0005, mk(16'hFFFE, 1'b1, 1'b0, 1'b0));
    run_op(16'hABCD, 16'hABCD, mk(16'h0000, 1'b0, 1'b1, 1'b0));
    run_op(16'h0000, 16'hFFFF, mk(16'h0001, 1'b1, 1'b0, 1'b0));

    // Start while busy: the second start must be ignored; diff holds 0x0001 until completion.
    @(negedge clk);
    a = 16'h9111; b = 16'h8765; start = 1'b1;
    q.push_back(mk(16'h09AC, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    do begin
      chk("busy_hold", 32'(busy), 32'd1);
      chk("diff_hold", 32'(diff), 32'h0001);
      @(posedge clk); #1;
      k++;
      if (k == 4) begin a = 16'hFFFF; b = 16'h0001; start = 1'b1; end
      if (k == 5) start = 1'b0;
    end while (done !== 1'b1 && k < 100);
    chk("busy_latency", 32'(k), 32'(W));
    repeat (2 * W) @(posedge clk);
    #1;
    chk("no_second_op", 32'(busy), 32'd0);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    a = 16'h4000; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, mk(16'h1000, 1'b0, 1'b0, 1'b0));
    run_op(16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b0, 1'b1));
    run_op(16'h7FFF, 16'h0001, mk(16'h7FFE, 1'b0, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    chk("pending", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; computes DIFF = A − B, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the team's combinational adders (ripple, ADD16); built for area-constrained datapaths that can tolerate multi-cycle latency.
- Start/done handshake; results held stable until the next operation completes.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  result A − B mod 2^WIDTH
- borrow  output  1  unsigned borrow-out (A < B)
- zero  output  1  diff == 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n, sampled on the rising edge of clk.
- Reset values: state=IDLE; busy=0, done=0, diff=0, borrow=0, zero=0; internal shift registers, borrow FF and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1, load a_sh←a, b_sh←b, bor←0, cnt←0; go to SHIFT.
- SHIFT: each edge computes d = a_sh[0]^b_sh[0]^bor and bor ← (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor).
  - Shifts d into d_sh MSB; shifts a_sh and b_sh right; cnt++.
  - On the edge where cnt reaches WIDTH−1 (the WIDTH-th bit op), go to DONE.
  - On that same edge, register diff←final d_sh, borrow←final bor, zero←(final d_sh==0), done←1.
- DONE: lasts one cycle with done=1; next edge → IDLE, done←0.
- Latency: start sampled at edge 0 → bit ops at edges 1..WIDTH → done high in the cycle after edge WIDTH. Next start is accepted at the earliest at edge WIDTH+2.
- Output stability: diff, borrow and zero change only on the completion edge. They hold the previous result through IDLE and SHIFT.
- start in SHIFT or DONE: ignored, not queued; a and b may change freely once start has been accepted.
- busy: combinational decode, state != IDLE.
- Reset mid-operation: abort the operation, return to reset values, no done pulse.
- Arithmetic: modulo 2^WIDTH; borrow=1 iff unsigned a < b; a==b gives diff=0, zero=1, borrow=0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: extra output port ovf (1 bit, reset 0). Registered on the completion edge as signed overflow = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the captured sign bits; held like diff.
- Undefined: no ovf port and no sign-capture logic.

Decomposition:
- Package serial_sub_pkg: state enum (IDLE, SHIFT, DONE) and default WIDTH constant.
- Sub-module full_sub_cell: combinational 1-bit full subtractor (x, y, bin → d, bout).
  - Instantiated once in the datapath.
  - Unit-testable alone over all 8 input combinations.

Test Plan:
- Basic: a=0x0005, b=0x0003, start 1 cycle → done after 16 cycles; diff=0x0002, borrow=0, zero=0.
- Borrow: a=0x0003, b=0x0005 → diff=0xFFFE, borrow=1, zero=0.
- Equal operands: a=0xABCD, b=0xABCD → diff=0x0000, zero=1, borrow=0. Then a=0x0000, b=0xFFFF → diff=0x0001, borrow=1.
- Start while busy:
  - Accept a=0x9111, b=0x8765.
  - Pulse start with a=0xFFFF, b=0x0001 at cycle 5.
  - Expect a single done with diff=0x09AC; busy stays high throughout; no second done.
- Reset mid-op: rst_n=0 at cycle 8 of an operation → next edge all outputs 0, IDLE, no done. A fresh start afterwards completes correctly.
- With SERIAL_SUB_OVF_EN:
  - a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1, borrow=0.
  - a=0x7FFF, b=0x0001 → ovf=0.
